// File: rtl/vector_packer.sv
// vector_packer: appends the first L lanes of each accepted vector (L chosen per
// chain by firmware) into dense N-lane output words, carrying leftover lanes
// across word boundaries. Partial words are emitted only on flush, which is
// triggered by leaving trace mode or by an idle timeout. Completed words go into
// a small valid/ready output FIFO. If the FIFO is full, the word is dropped and
// the drop is counted.
module vector_packer #(
    parameter int                            N                  = 8,
    parameter int                            DATA_WIDTH         = 32,
    parameter int                            MAX_CHAINS         = 4,
    parameter logic [7:0]                    PERSONAL_CONFIG_ID = 8'd0,
    parameter int                            FIFO_DEPTH         = 4,
    parameter int                            FLUSH_TIMEOUT      = 64,
    parameter logic [MAX_CHAINS-1:0][7:0]    INITIAL_LEN        = {MAX_CHAINS{8'd8}},
    parameter logic [MAX_CHAINS-1:0][7:0]    INITIAL_COND       = {MAX_CHAINS{8'd0}},
    localparam int                           CHAIN_W            = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1,
    localparam int                           LANE_W             = $clog2(N + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tracing,
    input  logic                             valid_in,
    input  logic [1:0]                       eof_in,
    input  logic [1:0]                       bof_in,
    input  logic [CHAIN_W-1:0]               chainId_in,
    input  logic [7:0]                       configId,
    input  logic [7:0]                       configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic [LANE_W-1:0]                lanes_out,
    output logic                             valid_out,
    input  logic                             ready_out,
    output logic [15:0]                      drop_count
);

    localparam int W      = N * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam int SUM_W  = LANE_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [MAX_CHAINS-1:0][7:0] len_q;
    logic [MAX_CHAINS-1:0][7:0] cond_q;
    logic [7:0]                 byte_cnt_q;

    logic [W-1:0]               acc_q;       // lanes >= fill_q are always zero
    logic [LANE_W-1:0]          fill_q;
    logic [IDLE_W-1:0]          idle_q;
    logic                       tracing_q;

    logic [W-1:0]               mem_data  [FIFO_DEPTH];
    logic [LANE_W-1:0]          mem_lanes [FIFO_DEPTH];
    logic [PTR_W:0]             wr_ptr_q;
    logic [PTR_W:0]             rd_ptr_q;
    logic [15:0]                drop_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [7:0]                 chain_len;
    logic [7:0]                 chain_cond;
    logic [LANE_W-1:0]          len_eff;
    logic [7:0]                 cond_hits;
    logic                       cond_ok;
    logic                       accept;

    logic [W-1:0]               in_flat;
    logic [W-1:0]               in_masked;
    logic [W-1:0]               merged;
    logic [W-1:0]               carry;
    logic [SUM_W-1:0]           sum;

    logic                       tracing_fall;
    logic                       timeout;

    logic                       push;
    logic [W-1:0]               push_data;
    logic [LANE_W-1:0]          push_lanes;
    logic [W-1:0]               acc_d;
    logic [LANE_W-1:0]          fill_d;
    logic [IDLE_W-1:0]          idle_d;

    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       pop;
    logic                       fifo_write;
    logic                       drop;

    assign in_flat = vector_in;

    // Select the configuration of the chain tagged on the incoming vector.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default first, so no path can leave it holding a value (which would infer a latch).
        chain_len  = '0;
        chain_cond = '0;
        for (int c = 0; c < MAX_CHAINS; c++) begin
            if (chainId_in == CHAIN_W'(c)) begin
                chain_len  = len_q[c];
                chain_cond = cond_q[c];
            end
        end
    end

    // Lengths above N are clamped to a full vector.
    assign len_eff = (chain_len > 8'(N)) ? LANE_W'(N) : chain_len[LANE_W-1:0];

    // Each condition bit selects one frame-flag polarity. Any selected match accepts the vector.
    assign cond_hits = {~bof_in[1], bof_in[1], ~eof_in[1], eof_in[1],
                        ~bof_in[0], bof_in[0], ~eof_in[0], eof_in[0]};
    assign cond_ok   = (chain_cond == 8'd0) || ((chain_cond & cond_hits) != 8'd0);
    assign accept    = valid_in & tracing & (len_eff != '0) & cond_ok;

    // Zero the lanes past L, so shifting the vector into place cannot pollute the accumulator.
    always_comb begin
        in_masked = '0;
        for (int i = 0; i < N; i++) begin
            if (LANE_W'(i) < len_eff) begin
                in_masked[i*DATA_WIDTH +: DATA_WIDTH] = in_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Place the new lanes after the current fill level. Lanes that overflow the word become the carry.
    // When fill is zero, the right shift spans the whole vector, so the carry is zero.
    assign merged = acc_q | (in_masked << (int'(fill_q) * DATA_WIDTH));
    assign carry  = in_masked >> ((N - int'(fill_q)) * DATA_WIDTH);
    assign sum    = SUM_W'(fill_q) + SUM_W'(len_eff);

    assign tracing_fall = tracing_q & ~tracing;
    assign timeout      = (FLUSH_TIMEOUT != 0) && (idle_q == IDLE_W'(FLUSH_TIMEOUT));

    // Next accumulator state and the word (if any) offered to the FIFO.
    // An accept takes priority over a timeout flush in the same cycle.
    always_comb begin
        push       = 1'b0;
        push_data  = acc_q;
        push_lanes = fill_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        idle_d     = idle_q;
        if (accept) begin
            idle_d = '0;
            if (sum >= SUM_W'(N)) begin
                push       = 1'b1;
                push_data  = merged;
                push_lanes = LANE_W'(N);
                acc_d      = carry;
                fill_d     = LANE_W'(sum - SUM_W'(N));
            end else begin
                acc_d  = merged;
                fill_d = sum[LANE_W-1:0];
            end
        end else if ((fill_q != '0) && (tracing_fall || timeout)) begin
            push   = 1'b1;
            acc_d  = '0;
            fill_d = '0;
            idle_d = '0;
        end else if (fill_q == '0) begin
            idle_d = '0;
        end else if (tracing && (idle_q != '1)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Accumulator, fill level, idle counter and trace-mode history.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every register in the design updates from the same pre-edge values.
        if (!rst_n) begin
            acc_q     <= '0;
            fill_q    <= '0;
            idle_q    <= '0;
            tracing_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            idle_q    <= idle_d;
            tracing_q <= tracing;
        end
    end

    // Configuration byte stream, written only in config mode.
    // Bytes 0..MAX_CHAINS-1 are condition bytes; the next MAX_CHAINS bytes are lane counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= INITIAL_LEN;
            cond_q     <= INITIAL_COND;
            byte_cnt_q <= '0;
        end else if (!tracing) begin
            if (configId == PERSONAL_CONFIG_ID) begin
                for (int c = 0; c < MAX_CHAINS; c++) begin
                    if (byte_cnt_q == 8'(c)) begin
                        cond_q[c] <= configData;
                    end
                    if (byte_cnt_q == 8'(MAX_CHAINS + c)) begin
                        len_q[c] <= configData;
                    end
                end
                if (byte_cnt_q != 8'hFF) begin
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                end
            end else begin
                byte_cnt_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign valid_out  = ~fifo_empty;
    assign pop        = valid_out & ready_out;
    // A pop that frees a slot in the same cycle lets a push into a full FIFO succeed.
    assign fifo_write = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;

    // FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; every entry is written before the pointers make it visible, and the outputs are masked while the FIFO is empty.
        if (fifo_write) begin
            mem_data[wr_ptr_q[PTR_W-1:0]]  <= push_data;
            mem_lanes[wr_ptr_q[PTR_W-1:0]] <= push_lanes;
        end
    end

    // FIFO pointers and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            if (fifo_write) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // The head stays stable while it waits for ready. An empty FIFO presents zeros.
    assign vector_out = valid_out ? mem_data[rd_ptr_q[PTR_W-1:0]]  : '0;
    assign lanes_out  = valid_out ? mem_lanes[rd_ptr_q[PTR_W-1:0]] : '0;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_vector_packer.sv
// tb_vector_packer: directed scenarios plus randomized traffic for vector_packer.
// Results are compared against a lane-queue reference model.
module tb_vector_packer;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int MC    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 4;
    localparam int CW    = N * DW;
    localparam int LW    = $clog2(N + 1);

    logic                clk;
    logic                rst_n;
    logic                tracing;
    logic                valid_in;
    logic [1:0]          eof_in;
    logic [1:0]          bof_in;
    logic [1:0]          chain;
    logic [7:0]          config_id;
    logic [7:0]          config_data;
    logic [N-1:0][DW-1:0] vec;
    logic [N-1:0][DW-1:0] vector_out;
    logic [LW-1:0]       lanes_out;
    logic                valid_out;
    logic                ready_out;
    logic [15:0]         drop_count;

    vector_packer #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(8'd0),
        .FIFO_DEPTH(DEPTH), .FLUSH_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .bof_in(bof_in), .chainId_in(chain),
        .configId(config_id), .configData(config_data), .vector_in(vec),
        .vector_out(vector_out), .lanes_out(lanes_out), .valid_out(valid_out),
        .ready_out(ready_out), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [CW-1:0] data;
        logic [LW-1:0] lanes;
    } word_t;

    word_t         exp_q[$];     // words expected in the output FIFO, head first
    logic [DW-1:0] pend_q[$];    // lanes accepted but not yet emitted
    int            m_len[MC];
    logic [7:0]    m_cond[MC];
    int            m_bc;
    int            m_idle;
    bit            m_trace_prev;
    int            m_drops;

    task automatic model_reset();
        exp_q.delete();
        pend_q.delete();
        for (int c = 0; c < MC; c++) begin
            m_len[c]  = 8;
            m_cond[c] = 8'd0;
        end
        m_bc = 0; m_idle = 0; m_trace_prev = 1'b0; m_drops = 0;
    endtask

    function automatic bit cond_match(input logic [7:0] c, input logic [1:0] e, input logic [1:0] b);
        if (c == 8'd0) return 1'b1;
        return (c[0] && e[0]) || (c[1] && !e[0]) || (c[2] && b[0]) || (c[3] && !b[0]) ||
               (c[4] && e[1]) || (c[5] && !e[1]) || (c[6] && b[1]) || (c[7] && !b[1]);
    endfunction

    task automatic model_push(input word_t w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else if (m_drops < 65535) m_drops++;
    endtask

    // One clock edge of the reference model, using the inputs presented at that edge.
    task automatic model_step();
        int    l;
        bit    acc;
        word_t w;
        if (exp_q.size() > 0 && ready_out) void'(exp_q.pop_front());
        l = m_len[chain];
        if (l > N) l = N;
        acc = tracing && valid_in && (l != 0) && cond_match(m_cond[chain], eof_in, bof_in);
        if (acc) begin
            for (int i = 0; i < l; i++) pend_q.push_back(vec[i]);
            m_idle = 0;
            if (pend_q.size() >= N) begin
                w.data = '0;
                for (int i = 0; i < N; i++) w.data[i*DW +: DW] = pend_q.pop_front();
                w.lanes = LW'(N);
                model_push(w);
            end
        end else if (pend_q.size() > 0 && ((m_trace_prev && !tracing) || m_idle == TMO)) begin
            w.data  = '0;
            w.lanes = LW'(pend_q.size());
            for (int i = 0; pend_q.size() > 0; i++) w.data[i*DW +: DW] = pend_q.pop_front();
            m_idle = 0;
            model_push(w);
        end else if (pend_q.size() == 0) begin
            m_idle = 0;
        end else if (tracing) begin
            m_idle++;
        end
        if (!tracing) begin
            if (config_id == 8'd0) begin
                if (m_bc < MC) m_cond[m_bc] = config_data;
                else if (m_bc < 2 * MC) m_len[m_bc - MC] = int'(config_data);
                if (m_bc < 255) m_bc++;
            end else begin
                m_bc = 0;
            end
        end
        m_trace_prev = tracing;
    endtask

    task automatic compare();
        check("valid_out", CW'(valid_out), CW'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("vector_out", vector_out, exp_q[0].data);
            check("lanes_out", CW'(lanes_out), CW'(exp_q[0].lanes));
        end
        check("drop_count", CW'(drop_count), CW'(m_drops));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [CW-1:0] mk_word(input int v[N]);
        logic [CW-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(v[i]);
        return w;
    endfunction

    function automatic logic [CW-1:0] seq_word(input int start);
        logic [CW-1:0] w;
        for (int i = 0; i < N; i++) w[i*DW +: DW] = DW'(start + i);
        return w;
    endfunction

    // Lanes 0..n-1 get base+i. The remaining lanes carry junk, which must never reach the output.
    task automatic set_vec(input int base, input int n);
        for (int i = 0; i < N; i++) vec[i] = (i < n) ? DW'(base + i) : (32'hDEAD_0000 | DW'(i));
    endtask

    task automatic cfg(input logic [7:0] bytes[2*MC]);
        tracing = 1'b0; valid_in = 1'b0; config_id = 8'hFF;
        step();
        config_id = 8'd0;
        for (int k = 0; k < 2 * MC; k++) begin
            config_data = bytes[k];
            step();
        end
        config_id = 8'hFF;
        step();
    endtask

    task automatic accept(input logic [1:0] ch, input logic [1:0] eof, input int base, input int n);
        tracing = 1'b1; valid_in = 1'b1; chain = ch; eof_in = eof; bof_in = 2'b00;
        set_vec(base, n);
        step();
        valid_in = 1'b0;
    endtask

    logic [7:0] rbytes[2*MC];
    int         vprob[4] = '{80, 30, 60, 10};

    initial begin
        rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; eof_in = '0; bof_in = '0;
        chain = '0; config_id = 8'hFF; config_data = '0; ready_out = 1'b1; vec = '0;
        model_reset();
        #12;
        check("rst_valid", CW'(valid_out), '0);
        check("rst_vector", vector_out, '0);
        check("rst_lanes", CW'(lanes_out), '0);
        check("rst_drops", CW'(drop_count), '0);
        @(posedge clk); #1; rst_n = 1'b1;

        // 1: LEN=3, eight accepts of lanes 1..24 -> three full words.
        cfg('{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd8, 8'd8, 8'd8});
        for (int k = 0; k < 8; k++) begin
            accept(2'd0, 2'b00, 3 * k + 1, 3);
            if (k == 2) check("t1_w0", vector_out, seq_word(1));
            if (k == 5) check("t1_w1", vector_out, seq_word(9));
            if (k == 7) check("t1_w2", vector_out, seq_word(17));
        end

        // 2: LEN=5, split across a word, then a tracing-fall flush of the carry.
        cfg('{8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd8, 8'd8, 8'd8});
        accept(2'd0, 2'b00, 101, 5);
        accept(2'd0, 2'b00, 201, 5);
        check("t2_word", vector_out, mk_word('{101, 102, 103, 104, 105, 201, 202, 203}));
        tracing = 1'b0;
        step();
        check("t2_flush", vector_out, mk_word('{204, 205, 0, 0, 0, 0, 0, 0}));
        check("t2_lanes", CW'(lanes_out), CW'(2));

        // 3: idle timeout flush, then an accept that coincides with the timeout.
        cfg('{8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd8, 8'd8, 8'd8});
        accept(2'd0, 2'b00, 301, 3);
        for (int t = 1; t <= 5; t++) begin
            step();
            check("t3_wait", CW'(valid_out), CW'(t == 5));
        end
        step();
        accept(2'd0, 2'b00, 401, 3);
        for (int t = 0; t < 4; t++) step();
        accept(2'd0, 2'b00, 411, 3);
        check("t3_noflush", CW'(valid_out), '0);
        for (int t = 0; t < 8; t++) step();

        // 4: backpressure with six full words into a 4-entry FIFO.
        cfg('{8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd8, 8'd8, 8'd8});
        ready_out = 1'b0;
        for (int k = 0; k < 6; k++) accept(2'd0, 2'b00, 1000 + 8 * k, 8);
        for (int t = 0; t < 3; t++) step();
        check("t4_drops", CW'(drop_count), CW'(2));
        check("t4_head", vector_out, seq_word(1000));
        ready_out = 1'b1;
        for (int t = 0; t < 5; t++) step();

        // 5: per-chain conditions and a disabled chain.
        cfg('{8'd1, 8'd0, 8'd0, 8'd0, 8'd2, 8'd8, 8'd0, 8'd8});
        accept(2'd0, 2'b00, 2000, 8);
        accept(2'd0, 2'b00, 2100, 8);
        accept(2'd2, 2'b01, 2200, 8);
        accept(2'd2, 2'b01, 2300, 8);
        for (int k = 0; k < 4; k++) accept(2'd0, 2'b01, 3000 + 8 * k, 8);
        check("t5_word", vector_out, mk_word('{3000, 3001, 3008, 3009, 3016, 3017, 3024, 3025}));
        step();

        // 6: asynchronous reset with fill=5 and two words queued.
        cfg('{8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd5, 8'd8, 8'd8});
        ready_out = 1'b0;
        accept(2'd0, 2'b00, 4000, 8);
        accept(2'd0, 2'b00, 4008, 8);
        accept(2'd1, 2'b00, 4016, 8);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_valid", CW'(valid_out), '0);
        check("t6_vector", vector_out, '0);
        check("t6_lanes", CW'(lanes_out), '0);
        check("t6_drops", CW'(drop_count), '0);
        @(posedge clk); #1; rst_n = 1'b1;
        ready_out = 1'b1;
        accept(2'd1, 2'b00, 5000, 8);
        check("t6_restart", vector_out, seq_word(5000));
        check("t6_rlanes", CW'(lanes_out), CW'(8));
        step();

        // Randomized traffic, with lane counts above N, conditions, backpressure and mode changes.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < MC; c++) begin
                rbytes[c]      = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
                rbytes[MC + c] = 8'($urandom_range(0, 10));
            end
            cfg(rbytes);
            for (int t = 0; t < 150; t++) begin
                tracing     = ($urandom_range(0, 19) != 0);
                valid_in    = ($urandom_range(0, 99) < vprob[r]);
                chain       = 2'($urandom_range(0, 3));
                eof_in      = 2'($urandom);
                bof_in      = 2'($urandom);
                ready_out   = ($urandom_range(0, 3) != 0);
                config_id   = (!tracing && $urandom_range(0, 9) == 0) ? 8'd0 : 8'hFF;
                config_data = 8'($urandom);
                for (int i = 0; i < N; i++) vec[i] = $urandom;
                step();
            end
        end
        valid_in = 1'b0; ready_out = 1'b1; tracing = 1'b0; config_id = 8'hFF;
        for (int t = 0; t < 8; t++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
